uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//  Sequences the UART receiver: captures each UART_Rx frame, handles framing errors via the err_ack
//  handshake, and buffers good words in a small FIFO drained by the host over valid/ready.
//  Sits between UART_Rx (r_clk domain) and the host register/bus interface. Same single clock.
// PARAMETERS
//  WORD_LENGTH    `WORD_LENGTH (8)          data bits per frame, = UART_pckt width
//  DEPTH          8                         FIFO entries; power of 2, >=2
//  BAUD_DIV       `Rx_CLKRATE/`BAUD         r_clk cycles per bit; used only by timeout
//  TIMEOUT_BAUDS  40                        idle bit-times before rx_timeout (4 chars @10b)
// PORTS
//  r_clk       in   1                  receive clock
//  r_rst_n     in   1                  async active-low reset
//  rx_en       in   1                  1 = accept frames; 0 = drop all, FSM to DISABLED
//  rx_pckt     in   WORD_LENGTH        UART_pckt from UART_Rx
//  rx_done     in   1                  1-cycle pulse: rx_pckt valid this cycle
//  rx_err      in   1                  framing error level from UART_Rx, held until err_ack
//  err_ack     out  1                  acknowledge to UART_Rx
//  rd_data     out  WORD_LENGTH        FIFO head
//  rd_valid    out  1                  FIFO not empty
//  rd_ready    in   1                  host pop; pop occurs when rd_valid & rd_ready
//  fifo_count  out  $clog2(DEPTH)+1    entries held, 0..DEPTH
//  ovf         out  1                  sticky: good frame dropped (FIFO full)
//  clr_ovf     in   1                  clears ovf; set wins if same cycle
//  err_cnt     out  8                  framing errors seen, saturates at 255
//  rx_timeout  out  1                  1-cycle pulse, see CONFIGURATION
// BEHAVIOUR
//  Async active-low reset: all outputs 0, FIFO empty, pointers 0, FSM IDLE.
//  FSM: DISABLED, IDLE, WRITE, ERR_HOLD.
//   DISABLED: rx_done/rx_err ignored; err_ack=0. rx_en=1 -> IDLE. FIFO contents retained, host may drain.
//   IDLE: rx_en=0 -> DISABLED (priority). rx_err=1 -> ERR_HOLD, err_cnt++ (sat).
//         else rx_done=1 -> latch rx_pckt, -> WRITE.
//   WRITE (1 cycle): push latched word if count<DEPTH or a pop occurs same cycle; else drop, ovf<=1.
//         -> IDLE. rx_done arriving while in WRITE is captured back-to-back (-> WRITE again).
//   ERR_HOLD: err_ack=1 (registered, first asserted cycle after entry); pckt discarded.
//         Exit to IDLE the cycle after rx_err samples 0; err_ack drops on that exit.
//         rx_en=0 here -> DISABLED, err_ack deasserts.
//  Latency: rx_done at cycle N -> entry written at N+1 edge -> rd_valid=1 at N+2 (from empty).
//  FIFO: rd_data is registered head, valid when rd_valid; no output change without a pop.
//   Ptrs $clog2(DEPTH) bits, wrap naturally; full/empty from fifo_count.
//   Simultaneous push+pop: count unchanged, both succeed, including at full and empty-with-bypass-off
//   (push to empty + pop impossible: rd_valid=0).
//   Pop when empty ignored. count never exceeds DEPTH nor underflows.
//  Reset mid-frame: everything reverts to reset values; partial state discarded.
// CONFIGURATION
//  `UART_RX_TIMEOUT_EN defined: 32-bit counter runs in IDLE while rd_valid=1; cleared on rx_done, pop,
//   or leaving IDLE. Reaching TIMEOUT_BAUDS*BAUD_DIV -> rx_timeout pulse 1 cycle, counter holds
//   (no repeat) until cleared.
//  Not defined: counter absent, rx_timeout tied 0.
// STRUCTURE
//  uart_pkg: typedef enum logic [1:0] rx_ctrl_state_e {DISABLED, IDLE, WRITE, ERR_HOLD};
//   localparams RX_BAUD_DIV, RX_WORD_LENGTH from globals.vh.
//  Sub-module uart_rx_fifo #(WIDTH, DEPTH): push/pop/data/count, no FSM knowledge.
// TESTING
//  1 Reset then rx_en=1, rx_done with 8'hA5, rd_ready=0 -> rd_valid=1 two cycles later, rd_data=A5, count=1.
//  2 Push 9 frames 8'h01..09, DEPTH=8, no pops -> count=8, ovf=1, pops return 01..08; clr_ovf -> ovf=0.
//  3 rx_err=1 for 5 cycles -> err_ack high from cycle 2 until 1 cycle after rx_err falls;
//    err_cnt=1; FIFO unchanged.
//  4 FIFO full, rd_ready=1 held while rx_done(8'h3C) -> no ovf, count stays 8, 3C at tail.
//  5 rx_en=0 then rx_done(8'hFF) -> ignored; assert r_rst_n=0 mid ERR_HOLD -> err_ack=0, count=0 async.
//  6 `UART_RX_TIMEOUT_EN, 1 word in FIFO, idle -> rx_timeout pulses once at 40*BAUD_DIV cycles;
//    pop cancels.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART receive-path types and build constants.
// RX_BAUD_DIV is r_clk cycles per bit at the configured line rate.
package uart_pkg;

  localparam int RX_WORD_LENGTH = 8;
  localparam int RX_BAUD_DIV    = 16;

  typedef enum logic [1:0] {
    DISABLED,
    IDLE,
    WRITE,
    ERR_HOLD
  } rx_ctrl_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO: push accepted when not full or when a pop lands the same cycle.
// Head word is read straight from storage flops; it only changes on a pop. Pop when empty is ignored.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  always_comb begin
    pop_ok   = pop && (count_q != '0);
    push_ok  = push && ((count_q != CW'(DEPTH)) || pop_ok);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign pop_dat = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: frame capture, framing-error ack handshake, word FIFO to host (valid/ready).
// rx_done -> rd_valid in 2 cycles; full FIFO drops the frame and sets sticky ovf. UART_RX_TIMEOUT_EN adds idle timeout.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int WORD_LENGTH   = RX_WORD_LENGTH,
  parameter int DEPTH         = 8,
  parameter int BAUD_DIV      = RX_BAUD_DIV,
  parameter int TIMEOUT_BAUDS = 40
) (
  input  logic                     r_clk,
  input  logic                     r_rst_n,
  input  logic                     rx_en,
  input  logic [WORD_LENGTH-1:0]   rx_pckt,
  input  logic                     rx_done,
  input  logic                     rx_err,
  output logic                     err_ack,
  output logic [WORD_LENGTH-1:0]   rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     ovf,
  input  logic                     clr_ovf,
  output logic [7:0]               err_cnt,
  output logic                     rx_timeout
);

  localparam int CW = $clog2(DEPTH) + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_BAUDS * BAUD_DIV <= 0) begin : g_param_chk
    $error("uart_rx_ctrl: DEPTH must be a power of 2 >= 2 and the timeout period positive");
  end

  rx_ctrl_state_e         state_q, state_d;
  logic [WORD_LENGTH-1:0] word_q, word_d;
  logic [7:0]             err_cnt_q, err_cnt_d;
  logic                   ovf_q, ovf_d;
  logic                   err_ack_q, err_ack_d;
  logic                   fifo_push, pop_fire, drop;

  assign pop_fire  = rd_valid && rd_ready;
  assign fifo_push = (state_q == WRITE);
  // A pop in the same cycle frees the slot, so only a truly full, undrained FIFO drops.
  assign drop      = fifo_push && (fifo_count == CW'(DEPTH)) && !pop_fire;

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    err_cnt_d = err_cnt_q;
    ovf_d     = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
    case (state_q)
      DISABLED: if (rx_en) state_d = IDLE;
      IDLE, WRITE: begin
        if (!rx_en) begin
          state_d = DISABLED;
        end else if (rx_err && state_q == IDLE) begin
          state_d = ERR_HOLD;
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end else if (rx_done) begin
          word_d  = rx_pckt;
          state_d = WRITE;
        end else begin
          state_d = IDLE;
        end
      end
      ERR_HOLD: begin
        if (!rx_en)       state_d = DISABLED;
        else if (!rx_err) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    err_ack_d = (state_d == ERR_HOLD);
  end

  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      state_q   <= IDLE;
      word_q    <= '0;
      err_cnt_q <= '0;
      ovf_q     <= 1'b0;
      err_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      err_cnt_q <= err_cnt_d;
      ovf_q     <= ovf_d;
      err_ack_q <= err_ack_d;
    end
  end

  uart_rx_fifo #(
    .WIDTH (WORD_LENGTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (r_clk),
    .rst_n    (r_rst_n),
    .push     (fifo_push),
    .push_dat (word_q),
    .pop      (rd_ready),
    .pop_dat  (rd_data),
    .count    (fifo_count)
  );

  assign rd_valid = (fifo_count != '0);
  assign err_ack  = err_ack_q;
  assign ovf      = ovf_q;
  assign err_cnt  = err_cnt_q;

`ifdef UART_RX_TIMEOUT_EN
  localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT_BAUDS * BAUD_DIV);

  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic        tmo_pulse_q, tmo_pulse_d;

  // Counter parks at the limit so the pulse fires once per idle stretch.
  always_comb begin
    tmo_cnt_d   = tmo_cnt_q;
    tmo_pulse_d = 1'b0;
    if (rx_done || pop_fire || state_q != IDLE) begin
      tmo_cnt_d = '0;
    end else if (rd_valid && tmo_cnt_q != TMO_LIMIT) begin
      tmo_cnt_d   = tmo_cnt_q + 32'd1;
      tmo_pulse_d = (tmo_cnt_d == TMO_LIMIT);
    end
  end

  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      tmo_cnt_q   <= '0;
      tmo_pulse_q <= 1'b0;
    end else begin
      tmo_cnt_q   <= tmo_cnt_d;
      tmo_pulse_q <= tmo_pulse_d;
    end
  end

  assign rx_timeout = tmo_pulse_q;
`else
  assign rx_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: capture latency, overflow, error handshake, full-with-pop, disable/reset, timeout.
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  localparam int W     = 8;
  localparam int DEPTH = 8;

  logic         r_clk = 1'b0;
  logic         r_rst_n;
  logic         rx_en;
  logic [W-1:0] rx_pckt;
  logic         rx_done;
  logic         rx_err;
  logic         err_ack;
  logic [W-1:0] rd_data;
  logic         rd_valid;
  logic         rd_ready;
  logic [3:0]   fifo_count;
  logic         ovf;
  logic         clr_ovf;
  logic [7:0]   err_cnt;
  logic         rx_timeout;

  int errors = 0;
  int checks = 0;

  uart_rx_ctrl #(.WORD_LENGTH(W), .DEPTH(DEPTH)) dut (
    .r_clk      (r_clk),
    .r_rst_n    (r_rst_n),
    .rx_en      (rx_en),
    .rx_pckt    (rx_pckt),
    .rx_done    (rx_done),
    .rx_err     (rx_err),
    .err_ack    (err_ack),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .fifo_count (fifo_count),
    .ovf        (ovf),
    .clr_ovf    (clr_ovf),
    .err_cnt    (err_cnt),
    .rx_timeout (rx_timeout)
  );

  always #5 r_clk = ~r_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic cycle();
    @(posedge r_clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] b);
    rx_done = 1'b1;
    rx_pckt = b;
    cycle();
    rx_done = 1'b0;
    cycle();
  endtask

  task automatic pop_one();
    rd_ready = 1'b1;
    cycle();
    rd_ready = 1'b0;
  endtask

`ifdef UART_RX_TIMEOUT_EN
  // Returns the cycle offset of the first rx_timeout pulse and the number of pulses seen.
  task automatic watch_timeout(input int span, output int first_k, output int pulses);
    first_k = -1;
    pulses  = 0;
    for (int k = 0; k <= span; k++) begin
      if (rx_timeout === 1'b1) begin
        pulses++;
        if (first_k < 0) first_k = k;
      end
      cycle();
    end
  endtask
`endif

  initial begin
    r_rst_n  = 1'b0;
    rx_en    = 1'b0;
    rx_pckt  = '0;
    rx_done  = 1'b0;
    rx_err   = 1'b0;
    rd_ready = 1'b0;
    clr_ovf  = 1'b0;
    #12;
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_count", 32'(fifo_count), 0);
    check("rst_err_ack", 32'(err_ack), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_err_cnt", 32'(err_cnt), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_timeout", 32'(rx_timeout), 0);
    r_rst_n = 1'b1;
    cycle();
    rx_en = 1'b1;
    cycle();

    // 1: capture latency
    rx_done = 1'b1;
    rx_pckt = 8'hA5;
    cycle();
    rx_done = 1'b0;
    check("t1_valid_n1", 32'(rd_valid), 0);
    cycle();
    check("t1_valid_n2", 32'(rd_valid), 1);
    check("t1_data", 32'(rd_data), 32'hA5);
    check("t1_count", 32'(fifo_count), 1);
    pop_one();
    check("t1_count_pop", 32'(fifo_count), 0);

    // 2: overflow on 9th frame, FIFO order preserved
    for (int i = 1; i <= 9; i++) send(W'(i));
    check("t2_count", 32'(fifo_count), 8);
    check("t2_ovf", 32'(ovf), 1);
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("t2_pop%0d", i), 32'(rd_data), 32'(i));
      pop_one();
    end
    check("t2_empty", 32'(fifo_count), 0);
    check("t2_ovf_sticky", 32'(ovf), 1);
    clr_ovf = 1'b1;
    cycle();
    clr_ovf = 1'b0;
    check("t2_ovf_clr", 32'(ovf), 0);

    // 3: error handshake; rx_done during ERR_HOLD is discarded
    send(8'h5A);
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("t3_ack_c%0d", k), 32'(err_ack), (k >= 2 && k <= 6) ? 32'd1 : 32'd0);
      rx_err  = (k <= 5);
      rx_done = (k == 3);
      rx_pckt = 8'h77;
      cycle();
    end
    rx_done = 1'b0;
    check("t3_err_cnt", 32'(err_cnt), 1);
    check("t3_count", 32'(fifo_count), 1);
    check("t3_head", 32'(rd_data), 32'h5A);
    pop_one();

    // 4: full FIFO, pop coinciding with the write
    for (int i = 0; i < 8; i++) send(8'h10 + W'(i));
    check("t4_full", 32'(fifo_count), 8);
    rx_done = 1'b1;
    rx_pckt = 8'h3C;
    cycle();
    rx_done  = 1'b0;
    rd_ready = 1'b1;
    cycle();
    rd_ready = 1'b0;
    check("t4_count", 32'(fifo_count), 8);
    check("t4_no_ovf", 32'(ovf), 0);
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("t4_pop%0d", i), 32'(rd_data), (i == 8) ? 32'h3C : 32'(8'h10 + i));
      pop_one();
    end
    check("t4_empty", 32'(fifo_count), 0);

    // 5: disabled ignores frames; async reset mid ERR_HOLD
    rx_en = 1'b0;
    cycle();
    send(8'hFF);
    cycle();
    check("t5_dis_count", 32'(fifo_count), 0);
    check("t5_dis_valid", 32'(rd_valid), 0);
    rx_en = 1'b1;
    cycle();
    send(8'h42);
    rx_err = 1'b1;
    cycle();
    cycle();
    check("t5_ack_hold", 32'(err_ack), 1);
    check("t5_cnt_pre", 32'(fifo_count), 1);
    #2;
    r_rst_n = 1'b0;
    #1;
    check("t5_rst_ack", 32'(err_ack), 0);
    check("t5_rst_count", 32'(fifo_count), 0);
    check("t5_rst_err_cnt", 32'(err_cnt), 0);
    rx_err = 1'b0;
    #3;
    r_rst_n = 1'b1;
    cycle();
    cycle();

`ifdef UART_RX_TIMEOUT_EN
    begin
      int lim, fk, np;
      lim = 40 * RX_BAUD_DIV;
      send(8'hC1);
      watch_timeout(lim + 20, fk, np);
      check("t6_pulses", 32'(np), 1);
      check("t6_when", 32'(fk), 32'(lim));
      send(8'hC2);
      watch_timeout(lim - 10, fk, np);
      check("t6_early", 32'(np), 0);
      pop_one();
      watch_timeout(lim + 20, fk, np);
      check("t6_pop_pulses", 32'(np), 1);
      check("t6_pop_when", 32'(fk), 32'(lim));
    end
`else
    send(8'hC1);
    for (int k = 0; k < 50; k++) cycle();
    check("t6_tied_off", 32'(rx_timeout), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
